// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state and memory-owner codes for the memory port arbiter
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_e;
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_LDR  = 2'b10;
endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// mem_port_arbiter_arb_select: CPU-priority winner pick with a loader anti-starvation streak counter
//   clk, reset     : clock, synchronous active-high reset
//   cpu_req        : CPU is requesting
//   ldr_req        : loader is requesting
//   exclude_owner  : master barred from this pick (the completing owner during hand-over)
//   grant_strobe   : the pick is taken this cycle; the streak counter advances
//   winner         : OWN_NONE / OWN_CPU / OWN_LDR
module mem_port_arbiter_arb_select
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_CPU_STREAK = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       ldr_req,
   input  logic [1:0] exclude_owner,
   input  logic       grant_strobe,
   output logic [1:0] winner
);
   localparam int SW = $clog2(MAX_CPU_STREAK + 1);
   logic [SW-1:0] streak_q, streak_d;
   logic          cpu_ok, ldr_ok, at_max, ldr_win;
   assign cpu_ok  = cpu_req && exclude_owner != OWN_CPU;
   assign ldr_ok  = ldr_req && exclude_owner != OWN_LDR;
   assign at_max  = streak_q == SW'(MAX_CPU_STREAK);
   assign ldr_win = ldr_ok && (!cpu_ok || at_max);
   assign winner  = ldr_win ? OWN_LDR : cpu_ok ? OWN_CPU : OWN_NONE;
   // Only CPU grants taken while the loader waits build the streak; it saturates at the limit.
   always_comb begin
      streak_d = streak_q;
      if (grant_strobe && winner != OWN_NONE)
         streak_d = ldr_win ? '0 : !ldr_req ? '0 : at_max ? streak_q : streak_q + SW'(1);
   end
   always_ff @(posedge clk) begin
      if (reset) streak_q <= '0;
      else       streak_q <= streak_d;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU and a loader/debug master
//   clk, reset                          : clock, synchronous active-high reset
//   cpu_req/we/adr/wdata -> rdata/ack   : CPU request and response; cpu_stall = cpu_req & ~cpu_ack
//   ldr_req/we/adr/wdata -> rdata/ack   : loader request and response
//   mem_en/we/adr/wdata, mem_rdata      : memory port, held for MEM_LAT cycles per access
//   owner                               : 00 none, 01 CPU, 10 loader (registered)
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int MEM_LAT        = 1,
   parameter int MAX_CPU_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_adr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);
   localparam int CW = $clog2(MEM_LAT + 1);
   state_e            state_q;
   logic [1:0]        owner_q, winner;
   logic [CW-1:0]     wait_q;
   logic              en_q, we_q, cpu_ack_q, ldr_ack_q, grant;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdata_q, cpu_rdata_q, ldr_rdata_q;
   // During hand-over the completing owner still holds req high, so it is barred from the pick.
   assign grant = state_q != ACCESS && winner != OWN_NONE;
   mem_port_arbiter_arb_select #(.MAX_CPU_STREAK(MAX_CPU_STREAK)) u_sel (
      .clk          (clk),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .ldr_req      (ldr_req),
      .exclude_owner(state_q == RESP ? owner_q : OWN_NONE),
      .grant_strobe (grant),
      .winner       (winner)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_NONE;
         wait_q      <= '0;
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         cpu_ack_q   <= 1'b0;
         ldr_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         ldr_ack_q <= 1'b0;
         if (state_q == ACCESS) begin
            wait_q <= wait_q - CW'(1);
            // Last access cycle: sample read data straight into the owner's result register.
            if (wait_q == CW'(1)) begin
               state_q   <= RESP;
               en_q      <= 1'b0;
               we_q      <= 1'b0;
               cpu_ack_q <= owner_q == OWN_CPU;
               ldr_ack_q <= owner_q == OWN_LDR;
               if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
               if (owner_q == OWN_LDR) ldr_rdata_q <= mem_rdata;
            end
         end else if (grant) begin
            state_q <= ACCESS;
            owner_q <= winner;
            wait_q  <= CW'(MEM_LAT);
            en_q    <= 1'b1;
            we_q    <= winner == OWN_LDR ? ldr_we : cpu_we;
            adr_q   <= winner == OWN_LDR ? ldr_adr : cpu_adr;
            wdata_q <= winner == OWN_LDR ? ldr_wdata : cpu_wdata;
         end else begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
         end
      end
   end
   assign cpu_stall = cpu_req && !cpu_ack_q;
   assign cpu_ack   = cpu_ack_q;
   assign ldr_ack   = ldr_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_adr   = adr_q;
   assign mem_wdata = wdata_q;
   assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random traffic on two arbiter configurations checked against a transaction-timeline model
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, ldr_req, ldr_we;
   logic [15:0] cpu_adr, cpu_wdata, ldr_adr, ldr_wdata, mem_rdata;
   logic [15:0] cpu_rdata [2], ldr_rdata [2], mem_adr [2], mem_wdata [2];
   logic        cpu_ack [2], cpu_stall [2], ldr_ack [2], mem_en [2], mem_we [2];
   logic [1:0]  owner [2];
   int          n_chk = 0, n_fail = 0;
   // Model: the one transaction in flight, described by who owns it and the cycle it was granted.
   int          act [2], who [2], start [2], streak [2];
   logic        tw [2];
   logic [15:0] ta [2], td [2], cap [2], crd [2], lrd [2];
   int          n_grant_ldr_forced = 0;
   always #5 clk = ~clk;
   mem_port_arbiter #(.MEM_LAT(1), .MAX_CPU_STREAK(4)) u0 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]), .cpu_stall(cpu_stall[0]),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adr(ldr_adr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata[0]), .ldr_ack(ldr_ack[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_adr(mem_adr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata), .owner(owner[0])
   );
   mem_port_arbiter #(.MEM_LAT(3), .MAX_CPU_STREAK(2)) u1 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]), .cpu_stall(cpu_stall[1]),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adr(ldr_adr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata[1]), .ldr_ack(ldr_ack[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_adr(mem_adr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata), .owner(owner[1])
   );
   function automatic int lat(input int k);
      return k == 0 ? 1 : 3;
   endfunction
   function automatic int mx(input int k);
      return k == 0 ? 4 : 2;
   endfunction
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_cycle(input int k, input int c);
      int   rel;
      logic en, resp, cack, lack;
      string p;
      rel  = c - start[k];
      en   = act[k] != 0 && rel >= 1 && rel <= lat(k);
      resp = act[k] != 0 && rel == lat(k) + 1;
      cack = resp && who[k] == 1;
      lack = resp && who[k] == 2;
      if (cack) crd[k] = cap[k];
      if (lack) lrd[k] = cap[k];
      p = $sformatf("dut%0d c%0d", k, c);
      check_eq({p, " owner"}, 32'(owner[k]), act[k] != 0 ? 32'(who[k]) : 32'd0);
      check_eq({p, " mem_en"}, 32'(mem_en[k]), 32'(en));
      check_eq({p, " mem_we"}, 32'(mem_we[k]), 32'(en && tw[k]));
      check_eq({p, " mem_adr"}, 32'(mem_adr[k]), 32'(ta[k]));
      check_eq({p, " mem_wdata"}, 32'(mem_wdata[k]), 32'(td[k]));
      check_eq({p, " cpu_ack"}, 32'(cpu_ack[k]), 32'(cack));
      check_eq({p, " ldr_ack"}, 32'(ldr_ack[k]), 32'(lack));
      check_eq({p, " cpu_rdata"}, 32'(cpu_rdata[k]), 32'(crd[k]));
      check_eq({p, " ldr_rdata"}, 32'(ldr_rdata[k]), 32'(lrd[k]));
      check_eq({p, " cpu_stall"}, 32'(cpu_stall[k]), 32'(cpu_req && !cack));
   endtask
   task automatic advance(input int k, input int c);
      int  rel, excl;
      bit  cok, lok;
      rel = c - start[k];
      if (reset) begin
         act[k] = 0; who[k] = 0; streak[k] = 0;
         tw[k] = 0; ta[k] = 0; td[k] = 0; crd[k] = 0; lrd[k] = 0;
         return;
      end
      if (act[k] != 0 && rel == lat(k)) cap[k] = mem_rdata;
      if (act[k] != 0 && rel != lat(k) + 1) return;
      excl = act[k] != 0 ? who[k] : 0;
      cok  = cpu_req && excl != 1;
      lok  = ldr_req && excl != 2;
      act[k] = 1;
      start[k] = c;
      if (lok && (!cok || streak[k] == mx(k))) begin
         if (cok) n_grant_ldr_forced++;
         who[k] = 2; streak[k] = 0;
         tw[k] = ldr_we; ta[k] = ldr_adr; td[k] = ldr_wdata;
      end else if (cok) begin
         who[k] = 1;
         streak[k] = !ldr_req ? 0 : streak[k] < mx(k) ? streak[k] + 1 : streak[k];
         tw[k] = cpu_we; ta[k] = cpu_adr; td[k] = cpu_wdata;
      end else begin
         act[k] = 0; who[k] = 0;
      end
   endtask
   initial begin
      reset = 1'b1;
      {cpu_req, cpu_we, ldr_req, ldr_we} = '0;
      {cpu_adr, cpu_wdata, ldr_adr, ldr_wdata, mem_rdata} = '0;
      for (int k = 0; k < 2; k++) begin
         act[k] = 0; who[k] = 0; start[k] = 0; streak[k] = 0;
         tw[k] = 0; ta[k] = 0; td[k] = 0; cap[k] = 0; crd[k] = 0; lrd[k] = 0;
      end
      repeat (2) @(posedge clk);
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         reset     = c < 2 || $urandom_range(0, 79) == 0;
         // Alternate calm stretches with heavy contention so hand-over and the streak limit both occur.
         cpu_req   = (c / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 1) == 0;
         ldr_req   = (c / 200) % 2 == 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 3) != 0;
         cpu_we    = 1'($urandom_range(0, 1));
         ldr_we    = 1'($urandom_range(0, 1));
         cpu_adr   = 16'($urandom);
         ldr_adr   = 16'($urandom);
         cpu_wdata = 16'($urandom);
         ldr_wdata = 16'($urandom);
         mem_rdata = 16'($urandom);
         #1;
         for (int k = 0; k < 2; k++) begin
            check_cycle(k, c);
            advance(k, c);
         end
      end
      check_eq("forced loader grants seen", 32'(n_grant_ldr_forced != 0), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
